flappy_game_ctrl: RTL and testbench

Game-flow controller that sequences the FlappyFPGA play loop from the keyboard decoder's level outputs (start = Enter, fly = Space, ret = Esc). It edge-detects the key levels, runs the IDLE/PLAY/DYING/OVER state machine and rate-limits flaps in frames. It also issues the world-reset pulse and keeps the current and best scores. It sits between the keyboard block and the bird/pipe/render logic, all in the clk25 domain.

---
 rtl/flappy_pkg.sv | 12 +
 rtl/flappy_game_ctrl_key_rise.sv | 27 ++
 rtl/flappy_game_ctrl.sv | 152 +++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared FlappyFPGA game-state encoding; render and physics blocks decode
// the controller's state output with these constants.
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

endpackage

// File: rtl/flappy_game_ctrl_key_rise.sv
// Rising-edge detector for one keyboard level. The rise is combinational
// from the live key and the registered previous level, so it has no extra latency.
module key_rise (
    input  logic clk25,
    input  logic clr_n,
    input  logic key,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = key;
        rise   = key & ~prev_q;
    end

    // Reset tracks the live level so a key held through reset is not a press.
    always_ff @(posedge clk25) begin
        if (!clr_n) begin
            prev_q <= key;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/flappy_game_ctrl.sv
// FlappyFPGA game-flow controller: key edges, IDLE/PLAY/DYING/OVER sequencing,
// flap rate limiting, world reset pulse and current/best score keeping.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int FLAP_COOLDOWN = 4,
    parameter int DIE_FRAMES    = 60,
    parameter int SCORE_W       = 10,
    parameter int SCORE_MAX     = 999
) (
    input  logic               clk25,
    input  logic               clr_n,
    input  logic               key_start,
    input  logic               key_fly,
    input  logic               key_ret,
    input  logic               frame_tick,
    input  logic               collide,
    input  logic               pipe_pass,
    output logic [1:0]         state,
    output logic               run_en,
    output logic               flap,
    output logic               game_rst,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score,
    output logic               new_best
);

    localparam int CD_W  = $clog2(FLAP_COOLDOWN + 1);
    localparam int DIE_W = $clog2(DIE_FRAMES + 1);

    logic start_rise, fly_rise, ret_rise;

    key_rise u_start (.clk25(clk25), .clr_n(clr_n), .key(key_start), .rise(start_rise));
    key_rise u_fly   (.clk25(clk25), .clr_n(clr_n), .key(key_fly),   .rise(fly_rise));
    key_rise u_ret   (.clk25(clk25), .clr_n(clr_n), .key(key_ret),   .rise(ret_rise));

    state_e             state_q, state_d;
    logic               run_en_q, run_en_d;
    logic               flap_q, flap_d;
    logic               game_rst_q, game_rst_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] hi_score_q, hi_score_d;
    logic               new_best_q, new_best_d;
    logic [CD_W-1:0]    cooldown_q, cooldown_d;
    logic [DIE_W-1:0]   die_cnt_q, die_cnt_d;

    always_comb begin
        state_d    = state_q;
        flap_d     = 1'b0;
        game_rst_d = 1'b0;
        score_d    = score_q;
        hi_score_d = hi_score_q;
        new_best_d = new_best_q;
        cooldown_d = cooldown_q;
        die_cnt_d  = die_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d    = ST_PLAY;
                    game_rst_d = 1'b1;
                    score_d    = '0;
                    cooldown_d = '0;
                    new_best_d = 1'b0;
                end
            end
            ST_PLAY: begin
                if (ret_rise) begin
                    state_d = ST_IDLE;
                end else if (collide) begin
                    state_d   = ST_DYING;
                    die_cnt_d = DIE_W'(DIE_FRAMES);
                end else begin
                    if (frame_tick && cooldown_q != '0)
                        cooldown_d = cooldown_q - 1'b1;
                    // A fresh flap reloads the full cooldown, overriding this tick.
                    if (fly_rise && cooldown_q == '0) begin
                        flap_d     = 1'b1;
                        cooldown_d = CD_W'(FLAP_COOLDOWN);
                    end
                    if (pipe_pass && score_q < SCORE_W'(SCORE_MAX))
                        score_d = score_q + 1'b1;
                end
            end
            ST_DYING: begin
                if (ret_rise) begin
                    state_d = ST_IDLE;
                end else if (frame_tick) begin
                    if (die_cnt_q <= DIE_W'(1)) begin
                        state_d = ST_OVER;
                        if (score_q > hi_score_q) begin
                            hi_score_d = score_q;
                            new_best_d = 1'b1;
                        end else begin
                            new_best_d = 1'b0;
                        end
                    end else begin
                        die_cnt_d = die_cnt_q - 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (ret_rise) begin
                    state_d    = ST_IDLE;
                    new_best_d = 1'b0;
                end else if (start_rise) begin
                    state_d    = ST_PLAY;
                    game_rst_d = 1'b1;
                    score_d    = '0;
                    cooldown_d = '0;
                    new_best_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        run_en_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk25) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            run_en_q   <= 1'b0;
            flap_q     <= 1'b0;
            game_rst_q <= 1'b0;
            score_q    <= '0;
            hi_score_q <= '0;
            new_best_q <= 1'b0;
            cooldown_q <= '0;
            die_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            run_en_q   <= run_en_d;
            flap_q     <= flap_d;
            game_rst_q <= game_rst_d;
            score_q    <= score_d;
            hi_score_q <= hi_score_d;
            new_best_q <= new_best_d;
            cooldown_q <= cooldown_d;
            die_cnt_q  <= die_cnt_d;
        end
    end

    assign state    = state_q;
    assign run_en   = run_en_q;
    assign flap     = flap_q;
    assign game_rst = game_rst_q;
    assign score    = score_q;
    assign hi_score = hi_score_q;
    assign new_best = new_best_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: directed scenarios with constant expectations,
// then a randomized run checked against a rule-level game model.
module tb_flappy_game_ctrl;

    logic       clk25 = 1'b0;
    logic       clr_n = 1'b0;
    logic       key_start = 1'b0, key_fly = 1'b0, key_ret = 1'b0;
    logic       frame_tick = 1'b0, collide = 1'b0, pipe_pass = 1'b0;
    logic [1:0] state;
    logic       run_en, flap, game_rst, new_best;
    logic [9:0] score, hi_score;

    int n_checks = 0;
    int n_fail   = 0;

    // Rule-level model: mode 0 idle, 1 playing, 2 dying, 3 game over.
    int m_mode, m_score, m_hi, m_cd, m_die;
    bit m_nb, m_flap, m_rst;
    bit pk_s, pk_f, pk_r;

    flappy_game_ctrl dut (
        .clk25(clk25), .clr_n(clr_n), .key_start(key_start), .key_fly(key_fly),
        .key_ret(key_ret), .frame_tick(frame_tick), .collide(collide),
        .pipe_pass(pipe_pass), .state(state), .run_en(run_en), .flap(flap),
        .game_rst(game_rst), .score(score), .hi_score(hi_score), .new_best(new_best)
    );

    always #20 clk25 = ~clk25;

    task automatic begin_run();
        m_mode = 1; m_rst = 1; m_score = 0; m_cd = 0; m_nb = 0;
    endtask

    task automatic model_edge();
        bit sr, fr, rr;
        m_flap = 0; m_rst = 0;
        if (!clr_n) begin
            m_mode = 0; m_score = 0; m_hi = 0; m_cd = 0; m_die = 0; m_nb = 0;
        end else begin
            sr = key_start && !pk_s;
            fr = key_fly && !pk_f;
            rr = key_ret && !pk_r;
            case (m_mode)
                0: if (sr) begin_run();
                1: begin
                    if (rr) m_mode = 0;
                    else if (collide) begin m_mode = 2; m_die = 60; end
                    else begin
                        if (fr && m_cd == 0) begin m_flap = 1; m_cd = 4; end
                        else if (frame_tick && m_cd > 0) m_cd = m_cd - 1;
                        if (pipe_pass && m_score < 999) m_score = m_score + 1;
                    end
                end
                2: begin
                    if (rr) m_mode = 0;
                    else if (frame_tick) begin
                        m_die = m_die - 1;
                        if (m_die == 0) begin
                            m_mode = 3;
                            m_nb = (m_score > m_hi);
                            if (m_score > m_hi) m_hi = m_score;
                        end
                    end
                end
                default: begin
                    if (rr) begin m_mode = 0; m_nb = 0; end
                    else if (sr) begin_run();
                end
            endcase
        end
        pk_s = key_start; pk_f = key_fly; pk_r = key_ret;
    endtask

    // Apply inputs, advance one edge, settle 1 time unit past it.
    task automatic step(input bit s, input bit f, input bit r,
                        input bit t, input bit c, input bit p);
        key_start = s; key_fly = f; key_ret = r;
        frame_tick = t; collide = c; pipe_pass = p;
        #1;
        model_edge();
        @(posedge clk25);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks_in_dying(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1, 1);
        n_checks++;
        if ({state, run_en, flap, game_rst, new_best, score, hi_score} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: state=%0d run_en=%b flap=%b game_rst=%b nb=%b score=%0d hi=%0d, expected all 0",
                     state, run_en, flap, game_rst, new_best, score, hi_score);
        end
        clr_n = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (state !== 2'd0 || game_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL held_start_after_reset: state=%0d game_rst=%b, expected state=0 game_rst=0", state, game_rst);
        end
        idle_cycles(2);
    endtask

    task automatic test_start();
        step(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (state !== 2'd1 || game_rst !== 1'b1 || run_en !== 1'b1 || score !== 10'd0) begin
            n_fail++;
            $display("FAIL start: state=%0d game_rst=%b run_en=%b score=%0d, expected 1/1/1/0", state, game_rst, run_en, score);
        end
        step(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (state !== 2'd1 || game_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL start_pulse_width: state=%0d game_rst=%b, expected state=1 game_rst=0", state, game_rst);
        end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_flap_limit();
        step(0, 1, 0, 0, 0, 0);
        n_checks++;
        if (flap !== 1'b1) begin
            n_fail++;
            $display("FAIL first_flap: flap=%b, expected 1", flap);
        end
        step(0, 1, 0, 0, 0, 0);
        n_checks++;
        if (flap !== 1'b0) begin
            n_fail++;
            $display("FAIL flap_pulse_width: flap=%b, expected 0", flap);
        end
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        n_checks++;
        if (flap !== 1'b0) begin
            n_fail++;
            $display("FAIL flap_during_cooldown: flap=%b, expected 0", flap);
        end
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        n_checks++;
        if (flap !== 1'b1) begin
            n_fail++;
            $display("FAIL flap_after_cooldown: flap=%b, expected 1", flap);
        end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_score();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0, 0);
        end
        n_checks++;
        if (score !== 10'd3) begin
            n_fail++;
            $display("FAIL score_three: score=%0d, expected 3", score);
        end
        step(0, 1, 0, 1, 1, 1);
        n_checks++;
        if (state !== 2'd2 || score !== 10'd3 || flap !== 1'b0 || run_en !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_priority: state=%0d score=%0d flap=%b run_en=%b, expected 2/3/0/0", state, score, flap, run_en);
        end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_death();
        // Entering DYING already consumed no tick; 59 more leave it in DYING.
        ticks_in_dying(59);
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL dying_duration: state=%0d after 59 ticks, expected 2", state);
        end
        step(0, 0, 0, 1, 0, 1);
        n_checks++;
        if (state !== 2'd3 || hi_score !== 10'd3 || new_best !== 1'b1 || run_en !== 1'b0) begin
            n_fail++;
            $display("FAIL over_new_best: state=%0d hi=%0d nb=%b run_en=%b, expected 3/3/1/0", state, hi_score, new_best, run_en);
        end
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        ticks_in_dying(60);
        n_checks++;
        if (state !== 2'd3 || hi_score !== 10'd3 || new_best !== 1'b0 || score !== 10'd3) begin
            n_fail++;
            $display("FAIL over_equal_score: state=%0d hi=%0d nb=%b score=%0d, expected 3/3/0/3", state, hi_score, new_best, score);
        end
    endtask

    task automatic test_priority();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 1);
        n_checks++;
        if (state !== 2'd0 || hi_score !== 10'd3 || score !== 10'd1) begin
            n_fail++;
            $display("FAIL ret_over_collide: state=%0d hi=%0d score=%0d, expected 0/3/1", state, hi_score, score);
        end
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        ticks_in_dying(60);
        step(1, 0, 1, 0, 0, 0);
        n_checks++;
        if (state !== 2'd0 || game_rst !== 1'b0 || new_best !== 1'b0) begin
            n_fail++;
            $display("FAIL start_and_ret_in_over: state=%0d game_rst=%b nb=%b, expected 0/0/0", state, game_rst, new_best);
        end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_saturate();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1001; i++) step(0, 0, 0, 0, 0, 1);
        n_checks++;
        if (score !== 10'd999) begin
            n_fail++;
            $display("FAIL score_saturate: score=%0d, expected 999", score);
        end
        step(0, 0, 0, 0, 1, 0);
        ticks_in_dying(60);
        n_checks++;
        if (hi_score !== 10'd999 || new_best !== 1'b1) begin
            n_fail++;
            $display("FAIL hi_saturated_run: hi=%0d nb=%b, expected 999/1", hi_score, new_best);
        end
    endtask

    task automatic test_random();
        bit s, f, r;
        clr_n = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        clr_n = 1'b1;
        s = 0; f = 0; r = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) s = ~s;
            if ($urandom_range(0, 1) == 0) f = ~f;
            if ($urandom_range(0, 40) == 0) r = ~r;
            step(s, f, r, $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0,
                 $urandom_range(0, 3) == 0);
            n_checks++;
            if ({state, run_en, flap, game_rst, new_best, score, hi_score} !==
                {m_mode[1:0], m_mode == 1, m_flap, m_rst, m_nb, m_score[9:0], m_hi[9:0]}) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: state=%0d run_en=%b flap=%b rst=%b nb=%b score=%0d hi=%0d, expected %0d/%b/%b/%b/%b/%0d/%0d",
                         i, state, run_en, flap, game_rst, new_best, score, hi_score,
                         m_mode, m_mode == 1, m_flap, m_rst, m_nb, m_score, m_hi);
            end
        end
    endtask

    initial begin
        pk_s = 0; pk_f = 0; pk_r = 0;
        test_reset();
        test_start();
        test_flap_limit();
        test_score();
        test_death();
        test_priority();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
